// File: rtl/pc_sequencer.sv
// Next-address controller for the CPU program counter.
// Sequential/jump/branch/call/return selection with a small return stack.
module pc_sequencer #(
  parameter int unsigned    AW        = 8,
  parameter int unsigned    DEPTH     = 4,
  parameter logic [AW-1:0]  RESET_VEC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     jmp,
  input  logic [AW-1:0]            jmp_addr,
  input  logic                     br,
  input  logic                     br_cond,
  input  logic [AW-1:0]            br_addr,
  input  logic                     call,
  input  logic [AW-1:0]            call_addr,
  input  logic                     ret,
  input  logic                     halt,
  input  logic                     resume,
  output logic [AW-1:0]            o_pc_next,
  output logic [AW-1:0]            o_pc,
  output logic [$clog2(DEPTH):0]   o_sp,
  output logic                     o_halted,
  output logic                     o_fault
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned SW = IW + 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          st, st_n;
  logic [AW-1:0]   pc_n;
  logic [SW-1:0]   sp_n;
  logic            push;
  logic [AW-1:0]   stk [DEPTH];
  logic [IW-1:0]   wr_idx, rd_idx;
  logic [AW-1:0]   pc_inc;

  assign wr_idx = o_sp[IW-1:0];
  assign rd_idx = o_sp[IW-1:0] - 1'b1;
  assign pc_inc = o_pc + 1'b1;

  always_comb begin
    pc_n = o_pc;
    sp_n = o_sp;
    st_n = st;
    push = 1'b0;
    case (st)
      RUN: begin
        if (en) begin
          // Priority chain: lower-priority requests are dropped.
          if (halt) begin
            st_n = HALT;
          end else if (ret) begin
            if (o_sp == '0) begin
              st_n = FAULT;
            end else begin
              pc_n = stk[rd_idx];
              sp_n = o_sp - 1'b1;
            end
          end else if (call) begin
            if (o_sp == SW'(DEPTH)) begin
              st_n = FAULT;
            end else begin
              push = 1'b1;
              pc_n = call_addr;
              sp_n = o_sp + 1'b1;
            end
          end else if (jmp) begin
            pc_n = jmp_addr;
          end else if (br && br_cond) begin
            pc_n = br_addr;
          end else begin
            pc_n = pc_inc;
          end
        end
      end
      HALT: begin
        if (resume) st_n = RUN;
      end
      default: ;
    endcase
  end

  assign o_pc_next = pc_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= RUN;
      o_pc     <= RESET_VEC;
      o_sp     <= '0;
      o_halted <= 1'b0;
      o_fault  <= 1'b0;
    end else begin
      st       <= st_n;
      o_pc     <= pc_n;
      o_sp     <= sp_n;
      o_halted <= (st_n == HALT);
      o_fault  <= (st_n == FAULT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) stk[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer.
// Vector table plus hand-written reset/wrap/fault/halt sequences.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, jmp, br, br_cond, call, ret, halt, resume;
  logic [7:0] jmp_addr, br_addr, call_addr;
  logic [7:0] o_pc_next, o_pc;
  logic [2:0] o_sp;
  logic       o_halted, o_fault;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.AW(8), .DEPTH(4), .RESET_VEC(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en),
    .jmp(jmp), .jmp_addr(jmp_addr),
    .br(br), .br_cond(br_cond), .br_addr(br_addr),
    .call(call), .call_addr(call_addr),
    .ret(ret), .halt(halt), .resume(resume),
    .o_pc_next(o_pc_next), .o_pc(o_pc), .o_sp(o_sp),
    .o_halted(o_halted), .o_fault(o_fault)
  );

  typedef struct packed {
    logic       en;
    logic       jmp;
    logic [7:0] ja;
    logic       br;
    logic       bc;
    logic [7:0] ba;
    logic       call;
    logic [7:0] ca;
    logic       ret;
    logic       halt;
    logic       resume;
  } in_t;

  typedef struct {
    in_t        i;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       h;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  function automatic vec_t mv(in_t i, logic [7:0] pc, logic [2:0] sp, logic h);
    vec_t v;
    v.i = i; v.pc = pc; v.sp = sp; v.h = h;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(in_t i);
    en = i.en; jmp = i.jmp; jmp_addr = i.ja;
    br = i.br; br_cond = i.bc; br_addr = i.ba;
    call = i.call; call_addr = i.ca;
    ret = i.ret; halt = i.halt; resume = i.resume;
  endtask

  // One cycle: drive, check next-PC before the edge, check state after.
  task automatic cyc(string nm, in_t i, logic [7:0] pc, logic [2:0] sp,
                     logic h, logic f);
    apply(i);
    #1;
    chk({nm, ".pc_next"}, 32'(o_pc_next), 32'(pc));
    @(posedge clk);
    #1;
    chk({nm, ".pc"}, 32'(o_pc), 32'(pc));
    chk({nm, ".sp"}, 32'(o_sp), 32'(sp));
    chk({nm, ".halted"}, 32'(o_halted), 32'(h));
    chk({nm, ".fault"}, 32'(o_fault), 32'(f));
  endtask

  task automatic do_reset();
    apply('{en: 1'b1, default: '0});
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst.pc", 32'(o_pc), 32'h00);
    chk("rst.sp", 32'(o_sp), 32'h0);
    chk("rst.flags", 32'({o_halted, o_fault}), 32'h0);
  endtask

  in_t idle;

  initial begin
    idle = '{en: 1'b1, default: '0};
    vt[0]  = mv('{en:1, jmp:1, ja:8'h10, default:0}, 8'h10, 0, 0);
    vt[1]  = mv('{en:1, br:1, bc:0, ba:8'h80, default:0}, 8'h11, 0, 0);
    vt[2]  = mv('{en:1, jmp:1, ja:8'h10, default:0}, 8'h10, 0, 0);
    vt[3]  = mv('{en:1, br:1, bc:1, ba:8'h80, default:0}, 8'h80, 0, 0);
    vt[4]  = mv('{en:1, jmp:1, ja:8'h10, default:0}, 8'h10, 0, 0);
    vt[5]  = mv('{en:1, jmp:1, ja:8'h20, br:1, bc:1, ba:8'h80, default:0}, 8'h20, 0, 0);
    vt[6]  = mv('{en:0, jmp:1, ja:8'h55, default:0}, 8'h20, 0, 0);
    vt[7]  = mv('{en:1, jmp:1, ja:8'h05, default:0}, 8'h05, 0, 0);
    vt[8]  = mv('{en:1, call:1, ca:8'h40, default:0}, 8'h40, 1, 0);
    vt[9]  = mv('{en:1, jmp:1, ja:8'h41, default:0}, 8'h41, 1, 0);
    vt[10] = mv('{en:1, call:1, ca:8'h90, default:0}, 8'h90, 2, 0);
    vt[11] = mv('{en:1, ret:1, call:1, ca:8'h77, jmp:1, ja:8'h11, default:0}, 8'h42, 1, 0);
    vt[12] = mv('{en:1, ret:1, default:0}, 8'h06, 0, 0);
    vt[13] = mv('{en:1, call:1, ca:8'hAA, jmp:1, ja:8'h11, default:0}, 8'hAA, 1, 0);
    vt[14] = mv('{en:1, ret:1, default:0}, 8'h07, 0, 0);
    vt[15] = mv('{en:1, jmp:1, ja:8'hFF, default:0}, 8'hFF, 0, 0);
    vt[16] = mv('{en:1, call:1, ca:8'h30, default:0}, 8'h30, 1, 0);
    vt[17] = mv('{en:1, ret:1, default:0}, 8'h00, 0, 0);
    vt[18] = mv('{en:1, halt:1, jmp:1, ja:8'h55, default:0}, 8'h00, 0, 1);
    vt[19] = mv('{en:1, jmp:1, ja:8'h55, default:0}, 8'h00, 0, 1);
    vt[20] = mv('{en:1, resume:1, jmp:1, ja:8'h55, default:0}, 8'h00, 0, 0);
    vt[21] = mv(idle, 8'h01, 0, 0);

    rst = 1'b0;
    apply(idle);
    do_reset();

    for (int k = 0; k < NV; k++)
      cyc($sformatf("vec%0d", k), vt[k].i, vt[k].pc, vt[k].sp, vt[k].h, 1'b0);

    // Asynchronous reset mid-run at pc=37, sp=2
    do_reset();
    cyc("t1a", '{en:1, call:1, ca:8'h10, default:0}, 8'h10, 1, 0, 0);
    cyc("t1b", '{en:1, call:1, ca:8'h36, default:0}, 8'h36, 2, 0, 0);
    cyc("t1c", idle, 8'h37, 2, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("t1.pc", 32'(o_pc), 32'h00);
    chk("t1.sp", 32'(o_sp), 32'h0);
    chk("t1.flags", 32'({o_halted, o_fault}), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    // 260 increments with wrap
    apply(idle);
    for (int k = 0; k < 260; k++) begin
      #1;
      chk("t2.next", 32'(o_pc_next), 32'(8'(o_pc + 8'd1)));
      @(posedge clk);
      #1;
    end
    chk("t2.pc", 32'(o_pc), 32'h04);

    // Overflow fault, then frozen
    do_reset();
    cyc("t5a", '{en:1, call:1, ca:8'h10, default:0}, 8'h10, 1, 0, 0);
    cyc("t5b", '{en:1, call:1, ca:8'h20, default:0}, 8'h20, 2, 0, 0);
    cyc("t5c", '{en:1, call:1, ca:8'h30, default:0}, 8'h30, 3, 0, 0);
    cyc("t5d", '{en:1, call:1, ca:8'h40, default:0}, 8'h40, 4, 0, 0);
    cyc("t5e", '{en:1, call:1, ca:8'h50, default:0}, 8'h40, 4, 0, 1);
    cyc("t5f", '{en:1, jmp:1, ja:8'h99, default:0}, 8'h40, 4, 0, 1);
    cyc("t5g", '{en:1, resume:1, ret:1, default:0}, 8'h40, 4, 0, 1);

    // Underflow fault
    do_reset();
    cyc("t5u", '{en:1, ret:1, default:0}, 8'h00, 0, 0, 1);
    cyc("t5v", idle, 8'h00, 0, 0, 1);

    // Halt, resume, stall
    do_reset();
    cyc("t6a", '{en:1, jmp:1, ja:8'h33, default:0}, 8'h33, 0, 0, 0);
    cyc("t6b", '{en:1, halt:1, default:0}, 8'h33, 0, 1, 0);
    for (int k = 0; k < 10; k++)
      cyc("t6h", '{en:1, jmp:1, ja:8'h77, call:1, ca:8'h66, default:0}, 8'h33, 0, 1, 0);
    cyc("t6r", '{en:1, resume:1, default:0}, 8'h33, 0, 0, 0);
    cyc("t6n", idle, 8'h34, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      cyc("t6s", '{en:0, jmp:1, ja:8'h77, halt:1, default:0}, 8'h34, 0, 0, 0);
    cyc("t6e", idle, 8'h35, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
